// File: rtl/matmul_loop_ctrl.sv
// matmul_loop_ctrl: loop sequencer for C[i][j] = sum_k A[i][k]*B[k][j].
// Issues operand reads, MAC strobes and result writes; pulses done per job.
module matmul_loop_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int MAX_DIM = 64,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       cfg_m,
  input  logic [31:0]       cfg_k,
  input  logic [31:0]       cfg_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_first,
  output logic              mac_last,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr
);

  localparam int IDX_W = $clog2(MAX_DIM + 1);
  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int LAT_M1_I = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT_M1_I);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [IDX_W-1:0] ONE_I = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  dim_m_q, dim_m_d;
  logic [IDX_W-1:0]  dim_k_q, dim_k_d;
  logic [IDX_W-1:0]  dim_n_q, dim_n_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              err_q, err_d;

  logic cfg_bad;
  logic k_last;
  logic j_last;
  logic i_last;
  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] n_ext;
  logic [ADDR_W-1:0] j_ext;

  assign cfg_bad = (cfg_m == 32'd0) || (cfg_m > 32'(MAX_DIM))
                || (cfg_k == 32'd0) || (cfg_k > 32'(MAX_DIM))
                || (cfg_n == 32'd0) || (cfg_n > 32'(MAX_DIM));

  assign k_last = (k_q == dim_k_q - ONE_I);
  assign j_last = (j_q == dim_n_q - ONE_I);
  assign i_last = (i_q == dim_m_q - ONE_I);

  assign k_ext = ADDR_W'(dim_k_q);
  assign n_ext = ADDR_W'(dim_n_q);
  assign j_ext = ADDR_W'(j_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = cfg_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!stall && k_last) begin
          state_d = (MAC_LAT == 0) ? S_WRITE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!stall && lat_q == '0) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!stall) begin
          state_d = (i_last && j_last) ? S_DONE : S_RUN;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    mac_first = 1'b0;
    mac_last  = 1'b0;
    c_we      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        busy      = 1'b1;
        rd_en     = !stall;
        mac_first = !stall && (k_q == '0);
        mac_last  = !stall && k_last;
      end
      S_DRAIN: busy = 1'b1;
      S_WRITE: begin
        busy = 1'b1;
        c_we = !stall;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign err    = err_q;
  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign c_addr = c_addr_q;

  // Addresses walk incrementally: a row base steps by K, b by N per k.
  always_comb begin
    dim_m_d  = dim_m_q;
    dim_k_d  = dim_k_q;
    dim_n_d  = dim_n_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    lat_d    = lat_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dim_m_d  = cfg_m[IDX_W-1:0];
          dim_k_d  = cfg_k[IDX_W-1:0];
          dim_n_d  = cfg_n[IDX_W-1:0];
          err_d    = cfg_bad;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          a_row_d  = '0;
          a_addr_d = '0;
          b_addr_d = '0;
          c_addr_d = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (k_last) begin
            lat_d = LAT_M1;
          end else begin
            k_d      = k_q + ONE_I;
            a_addr_d = a_addr_q + ONE_A;
            b_addr_d = b_addr_q + n_ext;
          end
        end
      end
      S_DRAIN: begin
        if (!stall && lat_q != '0) begin
          lat_d = lat_q - ONE_C;
        end
      end
      S_WRITE: begin
        if (!stall) begin
          c_addr_d = c_addr_q + ONE_A;
          k_d      = '0;
          if (j_last) begin
            j_d      = '0;
            i_d      = i_q + ONE_I;
            a_row_d  = a_row_q + k_ext;
            a_addr_d = a_row_q + k_ext;
            b_addr_d = '0;
          end else begin
            j_d      = j_q + ONE_I;
            a_addr_d = a_row_q;
            b_addr_d = j_ext + ONE_A;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_m_q  <= '0;
      dim_k_q  <= '0;
      dim_n_q  <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      lat_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      dim_m_q  <= dim_m_d;
      dim_k_q  <= dim_k_d;
      dim_n_q  <= dim_n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      lat_q    <= lat_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_matmul_loop_ctrl.sv
// tb_matmul_loop_ctrl: two sequencers (MAC_LAT 0 and 2) on shared stimulus,
// checked each cycle against a per-job schedule model plus literal values.
module tb_matmul_loop_ctrl;

  localparam int AW   = 16;
  localparam int MAXD = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] cfg_m = '0;
  logic [31:0] cfg_k = '0;
  logic [31:0] cfg_n = '0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic busy [2];
  logic done [2];
  logic err [2];
  logic rd_en [2];
  logic mac_first [2];
  logic mac_last [2];
  logic c_we [2];
  logic [AW-1:0] a_addr [2];
  logic [AW-1:0] b_addr [2];
  logic [AW-1:0] c_addr [2];

  always #5 clk = ~clk;

  matmul_loop_ctrl #(.ADDR_W(AW), .MAX_DIM(MAXD), .MAC_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .start(start), .stall(stall),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .rd_en(rd_en[0]), .a_addr(a_addr[0]), .b_addr(b_addr[0]),
    .mac_first(mac_first[0]), .mac_last(mac_last[0]),
    .c_we(c_we[0]), .c_addr(c_addr[0])
  );

  matmul_loop_ctrl #(.ADDR_W(AW), .MAX_DIM(MAXD), .MAC_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .start(start), .stall(stall),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .rd_en(rd_en[1]), .a_addr(a_addr[1]), .b_addr(b_addr[1]),
    .mac_first(mac_first[1]), .mac_last(mac_last[1]),
    .c_we(c_we[1]), .c_addr(c_addr[1])
  );

  typedef struct {
    bit busy, done, err, rd, first, last, we;
    int a, b, c;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  bit   merr [2];
  rec_t obs [2];
  int   checks = 0;
  int   errors = 0;

  int a0[$];
  int b0[$];
  int c0[$];
  int rd0c[$];
  int rd1c[$];
  int we1c[$];
  int done_at [2];

  task automatic push(input int d, input rec_t r);
    if (d == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Ideal unstalled cycle-by-cycle schedule of one job.
  task automatic build(input int d, input int m, input int k, input int n);
    rec_t r;
    bit bad;
    int lat;
    bad = (m == 0 || k == 0 || n == 0 || m > MAXD || k > MAXD || n > MAXD);
    lat = (d == 1) ? 2 : 0;
    merr[d] = bad;
    if (!bad) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n; j++) begin
          for (int kk = 0; kk < k; kk++) begin
            r = '{default:0};
            r.busy = 1; r.rd = 1;
            r.a = i * k + kk; r.b = kk * n + j;
            r.first = (kk == 0); r.last = (kk == k - 1);
            push(d, r);
          end
          for (int l = 0; l < lat; l++) begin
            r = '{default:0};
            r.busy = 1;
            push(d, r);
          end
          r = '{default:0};
          r.busy = 1; r.we = 1; r.c = i * n + j;
          push(d, r);
        end
      end
    end
    r = '{default:0};
    r.done = 1; r.err = bad;
    push(d, r);
  endtask

  function automatic bit same(input rec_t e, input rec_t g, input bit all);
    bit ok;
    ok = (e.busy == g.busy) && (e.done == g.done) && (e.err == g.err)
      && (e.rd == g.rd) && (e.first == g.first) && (e.last == g.last)
      && (e.we == g.we);
    if ((all || e.rd) && (e.a != g.a || e.b != g.b)) ok = 0;
    if ((all || e.we) && e.c != g.c) ok = 0;
    return ok;
  endfunction

  task automatic check_lane(input int d);
    rec_t e;
    rec_t g;
    bit idle;
    bit ok;
    g = '{default:0};
    g.busy = busy[d]; g.done = done[d]; g.err = err[d];
    g.rd = rd_en[d]; g.first = mac_first[d]; g.last = mac_last[d];
    g.we = c_we[d];
    g.a = int'(a_addr[d]); g.b = int'(b_addr[d]); g.c = int'(c_addr[d]);
    obs[d] = g;
    e = '{default:0};
    idle = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (!rst_n) begin
      if (d == 0) q0.delete();
      else q1.delete();
      merr[d] = 0;
      ok = same(e, g, 1);
    end else begin
      e.err = merr[d];
      if (!idle) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (stall && e.busy) begin
          e.rd = 0; e.first = 0; e.last = 0; e.we = 0;
        end else if (d == 0) begin
          void'(q0.pop_front());
        end else begin
          void'(q1.pop_front());
        end
      end
      ok = same(e, g, 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model_lat%0d t=%0t: got busy=%0d done=%0d err=%0d rd=%0d f=%0d l=%0d a=%0d b=%0d we=%0d c=%0d; expected busy=%0d done=%0d err=%0d rd=%0d f=%0d l=%0d a=%0d b=%0d we=%0d c=%0d",
               d * 2, $time, g.busy, g.done, g.err, g.rd, g.first, g.last,
               g.a, g.b, g.we, g.c, e.busy, e.done, e.err, e.rd, e.first,
               e.last, e.a, e.b, e.we, e.c);
    end
    if (rst_n && start && idle) begin
      build(d, int'(cfg_m), int'(cfg_k), int'(cfg_n));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_lane(0);
    check_lane(1);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic go(input int m, input int k, input int n,
                    input int s_lo, input int s_hi,
                    input int rs_cyc, input int rs_m);
    bit fin;
    a0.delete(); b0.delete(); c0.delete();
    rd0c.delete(); rd1c.delete(); we1c.delete();
    done_at[0] = -1;
    done_at[1] = -1;
    fin = 0;
    cfg_m = 32'(m); cfg_k = 32'(k); cfg_n = 32'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      stall = (c >= s_lo && c <= s_hi);
      start = (c == rs_cyc);
      if (c == rs_cyc) cfg_m = 32'(rs_m);
      tick();
      if (obs[0].rd) begin
        a0.push_back(obs[0].a);
        b0.push_back(obs[0].b);
        rd0c.push_back(c);
      end
      if (obs[0].we) c0.push_back(obs[0].c);
      if (obs[1].rd) rd1c.push_back(c);
      if (obs[1].we) we1c.push_back(c);
      for (int d = 0; d < 2; d++) begin
        if (obs[d].done && done_at[d] < 0) done_at[d] = c;
      end
      fin = (done_at[0] >= 0 && done_at[1] >= 0);
    end
    stall = 1'b0;
    start = 1'b0;
    if (!fin) lit("job_timeout", 0, 1);
  endtask

  task automatic seq_chk(input string name, input int got[$], input int exp[$]);
    lit({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      lit(name, got[i], exp[i]);
    end
  endtask

  initial begin
    int ea[$];
    int eb[$];
    int ec[$];

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    lit("reset_busy", int'(busy[1]), 0);
    lit("reset_a_addr", int'(a_addr[1]), 0);
    lit("reset_c_addr", int'(c_addr[0]), 0);

    // 1x1x1, plus a start landing on lat0's done cycle
    go(1, 1, 1, -1, -1, 2, 3);
    lit("t1_done_lat2", done_at[1], 4);
    lit("t1_done_lat0", done_at[0], 2);
    lit("t1_we_lat2", we1c.size() > 0 ? we1c[0] : -1, 3);
    lit("t1_rd_lat2", rd1c.size() > 0 ? rd1c[0] : -1, 0);
    lit("t1_err", int'(obs[1].err), 0);
    repeat (3) tick();
    lit("t1_idle_lat0", int'(busy[0]), 0);
    lit("t1_idle_lat2", int'(busy[1]), 0);

    // 2x3x2 address walk
    go(2, 3, 2, -1, -1, -1, 0);
    ea = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    eb = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
    ec = '{0, 1, 2, 3};
    seq_chk("t2_a_seq", a0, ea);
    seq_chk("t2_b_seq", b0, eb);
    seq_chk("t2_c_seq", c0, ec);
    lit("t2_done_lat0", done_at[0], 16);
    lit("t2_done_lat2", done_at[1], 24);

    // illegal dimensions
    go(2, 0, 2, -1, -1, -1, 0);
    lit("t3_k0_done", done_at[1], 0);
    lit("t3_k0_err", int'(obs[1].err), 1);
    lit("t3_k0_strobes", rd1c.size() + we1c.size() + c0.size(), 0);
    go(65, 1, 1, -1, -1, -1, 0);
    lit("t3_m65_done", done_at[0], 0);
    lit("t3_m65_err", int'(obs[0].err), 1);
    lit("t3_m65_strobes", rd0c.size() + rd1c.size() + c0.size(), 0);
    go(1, 2, 1, -1, -1, -1, 0);
    lit("t3_legal_err", int'(obs[1].err), 0);
    lit("t3_legal_done", done_at[1], 5);

    // stall for cycles 1..3
    go(2, 2, 2, 1, 3, -1, 0);
    lit("t4_k1_lat2", rd1c.size() > 1 ? rd1c[1] : -1, 4);
    lit("t4_k1_lat0", rd0c.size() > 1 ? rd0c[1] : -1, 4);
    lit("t4_done_lat2", done_at[1], 23);
    lit("t4_done_lat0", done_at[0], 15);

    // start while busy is ignored
    go(2, 2, 2, -1, -1, 2, 5);
    ea = '{0, 1, 0, 1, 2, 3, 2, 3};
    seq_chk("t5_a_seq", a0, ea);
    lit("t5_done_lat2", done_at[1], 20);
    lit("t5_done_lat0", done_at[0], 12);

    // mid-job reset
    cfg_m = 32'd4; cfg_k = 32'd4; cfg_n = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      lit("t6_rst_flags",
          int'({busy[d], done[d], err[d], rd_en[d], mac_first[d],
                mac_last[d], c_we[d]}), 0);
      lit("t6_rst_addr", int'(a_addr[d] | b_addr[d] | c_addr[d]), 0);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    lit("t6_no_done", int'(done[0]) + int'(done[1]), 0);
    go(1, 1, 1, -1, -1, -1, 0);
    lit("t6_after_done", done_at[1], 4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_loop_ctrl.md
# matmul_loop_ctrl

Loop sequencer for the matrix accelerator compute core. It sits directly downstream of the AXI-Lite control block and consumes its `cfg_m`/`cfg_k`/`cfg_n` and `start` pulse. It walks C[i][j] = Σk A[i][k]·B[k][j], issuing operand-buffer read addresses, MAC control strobes and result write strobes. It returns a one-cycle `done` pulse, which the control block latches into STATUS[0].

## Interface
- `ADDR_W`, default 16, width of the A/B/C buffer word addresses.
- `MAX_DIM`, default 64, largest legal value of M, K and N. MAX_DIM² must be ≤ 2^ADDR_W.
- `MAC_LAT`, default 2, cycles from the last operand beat until the MAC accumulator is valid. 0 is legal.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_m`, `cfg_k`, `cfg_n`  in  32 each  matrix dimensions. Sampled only on an accepted `start`.
- `start`  in  1  one-cycle trigger.
- `stall`  in  1  downstream backpressure. Freezes the sequencer.
- `busy`  out  1  a job is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  the last job was rejected for illegal dimensions.
- `rd_en`  out  1  operand read strobe, one beat.
- `a_addr`, `b_addr`  out  ADDR_W  operand addresses. Valid when `rd_en` is high.
- `mac_first`  out  1  marks the k=0 beat; the MAC clears its accumulator.
- `mac_last`  out  1  marks the k=K-1 beat.
- `c_we`  out  1  result write strobe.
- `c_addr`  out  ADDR_W  result address. Valid when `c_we` is high.

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: when `start` is high, latch M, K and N.
  - If any dimension is 0 or greater than MAX_DIM, set `err`=1 and go to DONE.
  - Otherwise set `err`=0, clear i, j and k, and go to RUN.
- `start` outside IDLE is ignored. It does not re-latch the configuration and does not clear `err`.
- RUN: each unstalled cycle drives `rd_en`=1 with a_addr = i·K+k and b_addr = k·N+j.
  - `mac_first` = (k==0). `mac_last` = (k==K-1).
  - k increments each beat. After the k=K-1 beat, go to DRAIN, or to WRITE if MAC_LAT=0.
- DRAIN: wait exactly MAC_LAT unstalled cycles using a down-counter, then go to WRITE.
- WRITE: one unstalled cycle with `c_we`=1 and c_addr = i·N+j. Then advance the indices:
  - j increments.
  - On j==N-1, j wraps to 0 and i increments.
  - On i==M-1 and j==N-1, go to DONE; otherwise clear k and return to RUN.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. DONE ignores `stall`.
- Addresses are generated incrementally with no multipliers:
  - a row base advances by K on each i step.
  - b_addr advances by N on each k step.
  - c_addr advances by 1 on each WRITE.
  - All address arithmetic is modulo 2^ADDR_W. Legal dimensions never wrap.
- `stall`=1 in RUN, DRAIN or WRITE:
  - State, indices and counters hold.
  - `rd_en`, `c_we`, `mac_first` and `mac_last` are forced to 0.
  - Address outputs hold their values.
- `busy` = 1 in RUN, DRAIN and WRITE. It is 0 in IDLE and DONE.

## Timing
- Reset (async assert, sync release): state IDLE; `busy`, `done`, `err`, `rd_en`, `mac_first`, `mac_last` and `c_we` = 0; `a_addr`, `b_addr` and `c_addr` = 0.
- Cycle numbering: `start` is sampled at edge E0; cycle 0 is the cycle after E0. With no stalls, per output element e:
  - cycles e·P … e·P+K-1 carry the K read beats, where P = K+MAC_LAT+1;
  - the next MAC_LAT cycles are DRAIN;
  - cycle e·P+K+MAC_LAT carries `c_we`.
- `done` is high in cycle M·N·P.
- Each stall cycle delays all later events by one cycle.
- An illegal configuration gives `done`=1 and `err`=1 in cycle 0, with no `rd_en` and no `c_we`.
- Back-to-back jobs: `start` is accepted no earlier than the cycle after `done`. A `start` coinciding with `done` is ignored.
- All outputs are registered or decoded from registered state only. There is no combinational path from `start` or `stall` to the outputs, except the stall gating of the strobes.
- `rst_n` asserted mid-job aborts immediately. No `done` is produced.

## Test plan
- M=K=N=1, MAC_LAT=2, start → cycle 0: `rd_en`, a=0, b=0, `mac_first`=`mac_last`=1; cycle 3: `c_we`, c_addr=0; cycle 4: `done`; `err`=0.
- M=2, K=3, N=2, MAC_LAT=0 →
  - a_addr sequence: 0,1,2 | 0,1,2 | 3,4,5 | 3,4,5.
  - b_addr sequence: 0,2,4 | 1,3,5 | 0,2,4 | 1,3,5.
  - c_addr sequence: 0,1,2,3.
  - `done` in cycle 16.
- cfg_k=0, then cfg_m=65 with MAX_DIM=64 → each gives `done`+`err` in cycle 0 with no strobes. A following legal job clears `err`.
- M=K=N=2, `stall` high for cycles 1–3 → no strobes in cycles 1–3; the beat for k=1 appears in cycle 4; `done` is 3 cycles later than the unstalled run.
- Second `start` in cycle 2 of a running M=K=N=2 job with new cfg_m=5 → ignored; addresses and `done` timing match the original job.
- `rst_n` pulsed low in cycle 5 of a 4x4x4 job → all outputs 0 immediately, no `done`; a new start behaves as from reset.
